// File: rtl/toggle_event_receiver.sv
// Toggle-signalling receive end: synchronizes a remote toggle line, turns each flip
// into a pending event, and returns one acknowledge flip per consumed event.
module toggle_event_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgl_in,
    output logic             evt_pulse,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_count,
    output logic             ack_tgl,
    output logic             overflow,
    input  logic             clr_ovf
);

    typedef enum logic {PRIME = 1'b0, RUN = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [2:0]       PRIME_LAST = 3'(SYNC_STAGES);

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_ref;
    logic [2:0]             r_prime_cnt;

    logic w_sync_out;
    logic w_edge;
    logic w_accept;
    logic w_lost;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    // Edges are only recognised once the reference bit has been primed.
    assign w_edge     = (r_state == RUN) && (w_sync_out != r_ref);
    assign evt_valid  = (evt_count != '0);
    assign w_accept   = evt_valid & evt_ready;
    assign w_lost     = w_edge & ~w_accept & (evt_count == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= PRIME;
            r_sync      <= '0;
            r_ref       <= 1'b0;
            r_prime_cnt <= '0;
            evt_pulse   <= 1'b0;
            evt_count   <= '0;
            ack_tgl     <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], tgl_in};
            evt_pulse <= w_edge;

            case (r_state)
                PRIME: begin
                    if (r_prime_cnt == PRIME_LAST) begin
                        r_ref   <= w_sync_out;
                        r_state <= RUN;
                    end else begin
                        r_prime_cnt <= r_prime_cnt + 3'd1;
                    end
                end
                RUN:     r_ref <= w_sync_out;
                default: r_state <= PRIME;
            endcase

            // Push and accept together leave the count as is.
            if (w_edge && !w_accept && evt_count != CNT_MAX)
                evt_count <= evt_count + 1'b1;
            else if (!w_edge && w_accept)
                evt_count <= evt_count - 1'b1;

            if (w_accept)
                ack_tgl <= ~ack_tgl;

            if (w_lost)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

endmodule
